// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bus: stage stall requests, interrupt/MRET inputs, and the stall/flush/redirect/CSR-write outputs.
// The master modport belongs to the pipeline side; the slave modport belongs to pipe_ctrl.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef CSR_ADDR_WIDTH
`define CSR_ADDR_WIDTH 12
`endif

interface pipe_ctrl_if;
    logic                       stallreq_if_i;
    logic                       stallreq_id_i;
    logic                       stallreq_ex_i;
    logic                       stallreq_mem_i;
    logic                       int_req_i;
    logic                       int_en_i;
    logic [`DATA_WIDTH-1:0]     epc_i;
    logic [`DATA_WIDTH-1:0]     mtvec_i;
    logic [`DATA_WIDTH-1:0]     mepc_i;
    logic                       mret_i;
    logic [5:0]                 stall_o;
    logic                       flush_o;
    logic                       flush_int_o;
    logic [`DATA_WIDTH-1:0]     new_pc_o;
    logic                       new_pc_valid_o;
    logic                       int_ack_o;
    logic                       csr_we_o;
    logic [`CSR_ADDR_WIDTH-1:0] csr_waddr_o;
    logic [`DATA_WIDTH-1:0]     csr_wdata_o;

    modport master (
        output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output int_req_i, int_en_i, epc_i, mtvec_i, mepc_i, mret_i,
        input  stall_o, flush_o, flush_int_o, new_pc_o, new_pc_valid_o, int_ack_o,
        input  csr_we_o, csr_waddr_o, csr_wdata_o
    );

    modport slave (
        input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  int_req_i, int_en_i, epc_i, mtvec_i, mepc_i, mret_i,
        output stall_o, flush_o, flush_int_o, new_pc_o, new_pc_valid_o, int_ack_o,
        output csr_we_o, csr_waddr_o, csr_wdata_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/trap controller: outputs decoded combinationally from state; interrupt entry 3 cycles, MRET redirect same cycle.
// A pending memory stall holds the trap in DRAIN; CTRL_DRAIN_TIMEOUT_EN adds a 15-cycle drain watchdog with sticky timeout_o.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef CSR_ADDR_WIDTH
`define CSR_ADDR_WIDTH 12
`endif

module pipe_ctrl (
    input  logic           clk_i,
    input  logic           rst_i,
    pipe_ctrl_if.slave     bus
`ifdef CTRL_DRAIN_TIMEOUT_EN
    ,
    output logic           timeout_o
`endif
);
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] DRAIN      = 2'd1;
    localparam logic [1:0] TRAP_EPC   = 2'd2;
    localparam logic [1:0] TRAP_CAUSE = 2'd3;

    localparam logic [`CSR_ADDR_WIDTH-1:0] CSR_MEPC   = `CSR_ADDR_WIDTH'h341;
    localparam logic [`CSR_ADDR_WIDTH-1:0] CSR_MCAUSE = `CSR_ADDR_WIDTH'h342;
    localparam logic [`DATA_WIDTH-1:0]     CAUSE_MEI  = `DATA_WIDTH'h8000000B;

    logic [1:0] state_q, state_d;
    logic       take_int;
    logic       drain_expire;
    logic [5:0] stall_prio;

    assign take_int = bus.int_req_i & bus.int_en_i;

    always_comb begin
        stall_prio = 6'b000000;
        if (bus.stallreq_mem_i)     stall_prio = 6'b011111;
        else if (bus.stallreq_ex_i) stall_prio = 6'b001111;
        else if (bus.stallreq_id_i) stall_prio = 6'b000111;
        else if (bus.stallreq_if_i) stall_prio = 6'b000011;
    end

`ifdef CTRL_DRAIN_TIMEOUT_EN
    logic [3:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    // Count is 0 in the first DRAIN cycle, so cnt_q==14 marks the 15th one.
    always_comb begin
        cnt_d        = (state_q == DRAIN) ? cnt_q + 4'd1 : 4'd0;
        drain_expire = (state_q == DRAIN) && bus.stallreq_mem_i && (cnt_q == 4'd14);
        timeout_d    = timeout_q | drain_expire;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= 4'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign drain_expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (take_int) state_d = bus.stallreq_mem_i ? DRAIN : TRAP_EPC;
            DRAIN:      if (!bus.stallreq_mem_i || drain_expire) state_d = TRAP_EPC;
            TRAP_EPC:   state_d = TRAP_CAUSE;
            TRAP_CAUSE: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Reset gates every output so a trap cut short by reset writes nothing.
    always_comb begin
        bus.stall_o        = 6'b000000;
        bus.flush_o        = 1'b0;
        bus.flush_int_o    = 1'b0;
        bus.new_pc_o       = '0;
        bus.new_pc_valid_o = 1'b0;
        bus.int_ack_o      = 1'b0;
        bus.csr_we_o       = 1'b0;
        bus.csr_waddr_o    = '0;
        bus.csr_wdata_o    = '0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    bus.stall_o = stall_prio;
                    if (bus.mret_i && !take_int) begin
                        bus.flush_o        = 1'b1;
                        bus.new_pc_valid_o = 1'b1;
                        bus.new_pc_o       = bus.mepc_i;
                    end
                end
                DRAIN: bus.stall_o = stall_prio;
                TRAP_EPC: begin
                    bus.stall_o     = 6'b000001;
                    bus.flush_o     = 1'b1;
                    bus.flush_int_o = 1'b1;
                    bus.csr_we_o    = 1'b1;
                    bus.csr_waddr_o = CSR_MEPC;
                    bus.csr_wdata_o = bus.epc_i;
                end
                TRAP_CAUSE: begin
                    bus.flush_o        = 1'b1;
                    bus.csr_we_o       = 1'b1;
                    bus.csr_waddr_o    = CSR_MCAUSE;
                    bus.csr_wdata_o    = CAUSE_MEI;
                    bus.new_pc_valid_o = 1'b1;
                    bus.new_pc_o       = bus.mtvec_i;
                    bus.int_ack_o      = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: inputs driven on the falling edge, outputs checked 1ns later.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    pipe_ctrl_if bus();
`ifdef CTRL_DRAIN_TIMEOUT_EN
    logic timeout;
`endif

    pipe_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef CTRL_DRAIN_TIMEOUT_EN
        ,
        .timeout_o (timeout)
`endif
    );

    always #5 clk = ~clk;

    // {flush, flush_int, csr_we, int_ack, new_pc_valid}
    logic [4:0] flags;
    assign flags = {bus.flush_o, bus.flush_int_o, bus.csr_we_o, bus.int_ack_o, bus.new_pc_valid_o};

    task automatic clear_inputs();
        bus.stallreq_if_i  = 1'b0;
        bus.stallreq_id_i  = 1'b0;
        bus.stallreq_ex_i  = 1'b0;
        bus.stallreq_mem_i = 1'b0;
        bus.int_req_i      = 1'b0;
        bus.int_en_i       = 1'b0;
        bus.mret_i         = 1'b0;
        bus.epc_i          = 32'h0;
        bus.mtvec_i        = 32'h0;
        bus.mepc_i         = 32'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        bus.stallreq_mem_i = 1'b1;
        bus.int_req_i = 1'b1;
        bus.int_en_i  = 1'b1;
        bus.mret_i    = 1'b1;
        bus.mepc_i    = 32'h84;
        @(negedge clk); #1;
        n_checks++; if (bus.stall_o !== 6'b000000) begin n_fail++; $display("FAIL reset_stall: got %b want 000000", bus.stall_o); end
        n_checks++; if (flags !== 5'b00000) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", flags); end
        n_checks++; if (bus.new_pc_o !== 32'h0 || bus.csr_waddr_o !== 12'h0 || bus.csr_wdata_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_buses: pc %h addr %h data %h want all 0", bus.new_pc_o, bus.csr_waddr_o, bus.csr_wdata_o); end
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        #1;
        n_checks++; if (flags !== 5'b00000 || bus.stall_o !== 6'b000000) begin
            n_fail++; $display("FAIL post_reset_idle: flags %b stall %b want 0", flags, bus.stall_o); end
    endtask

    task automatic test_stall_priority();
        logic [3:0] req [7];   // {mem, ex, id, if}
        logic [5:0] exp [7];
        req = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0101, 4'b1111};
        exp = '{6'b000000, 6'b000011, 6'b000111, 6'b001111, 6'b011111, 6'b001111, 6'b011111};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            {bus.stallreq_mem_i, bus.stallreq_ex_i, bus.stallreq_id_i, bus.stallreq_if_i} = req[i];
            #1;
            n_checks++; if (bus.stall_o !== exp[i]) begin
                n_fail++; $display("FAIL stall_prio req=%b: got %b want %b", req[i], bus.stall_o, exp[i]); end
        end
        clear_inputs();
    endtask

    task automatic test_interrupt_entry();
        @(negedge clk);
        bus.int_req_i = 1'b1; bus.int_en_i = 1'b1;
        bus.epc_i = 32'h80; bus.mtvec_i = 32'h100;
        #1;
        n_checks++; if (flags !== 5'b00000 || bus.stall_o !== 6'b000000) begin
            n_fail++; $display("FAIL int_req_cycle: flags %b stall %b want 0", flags, bus.stall_o); end
        // TRAP_EPC: mret and stall requests must be ignored
        @(negedge clk);
        bus.int_req_i = 1'b0;
        bus.mret_i = 1'b1; bus.mepc_i = 32'h84; bus.stallreq_mem_i = 1'b1;
        #1;
        n_checks++; if (flags !== 5'b11100) begin n_fail++; $display("FAIL epc_flags: got %b want 11100", flags); end
        n_checks++; if (bus.stall_o !== 6'b000001) begin n_fail++; $display("FAIL epc_stall: got %b want 000001", bus.stall_o); end
        n_checks++; if (bus.csr_waddr_o !== 12'h341 || bus.csr_wdata_o !== 32'h80) begin
            n_fail++; $display("FAIL epc_write: addr %h data %h want 341/00000080", bus.csr_waddr_o, bus.csr_wdata_o); end
        @(negedge clk);
        bus.stallreq_mem_i = 1'b0;
        #1;
        n_checks++; if (flags !== 5'b10111) begin n_fail++; $display("FAIL cause_flags: got %b want 10111", flags); end
        n_checks++; if (bus.csr_waddr_o !== 12'h342 || bus.csr_wdata_o !== 32'h8000000B) begin
            n_fail++; $display("FAIL cause_write: addr %h data %h want 342/8000000b", bus.csr_waddr_o, bus.csr_wdata_o); end
        n_checks++; if (bus.new_pc_o !== 32'h100 || bus.stall_o !== 6'b000000) begin
            n_fail++; $display("FAIL cause_redirect: pc %h stall %b want 100/000000", bus.new_pc_o, bus.stall_o); end
        @(negedge clk);
        bus.mret_i = 1'b0;
        #1;
        n_checks++; if (flags !== 5'b00000 || bus.csr_waddr_o !== 12'h0 || bus.new_pc_o !== 32'h0) begin
            n_fail++; $display("FAIL entry_back_idle: flags %b addr %h pc %h want 0", flags, bus.csr_waddr_o, bus.new_pc_o); end
        clear_inputs();
    endtask

    task automatic test_drain();
        @(negedge clk);
        bus.int_req_i = 1'b1; bus.int_en_i = 1'b1; bus.stallreq_mem_i = 1'b1;
        bus.epc_i = 32'h40; bus.mtvec_i = 32'h200;
        #1;
        n_checks++; if (bus.stall_o !== 6'b011111 || flags !== 5'b00000) begin
            n_fail++; $display("FAIL drain_req_cycle: stall %b flags %b want 011111/00000", bus.stall_o, flags); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.int_req_i = 1'b0;
            #1;
            n_checks++; if (bus.stall_o !== 6'b011111 || flags !== 5'b00000) begin
                n_fail++; $display("FAIL drain_hold cyc%0d: stall %b flags %b want 011111/00000", i, bus.stall_o, flags); end
        end
        @(negedge clk);
        bus.stallreq_mem_i = 1'b0;
        #1;
        n_checks++; if (bus.csr_we_o !== 1'b0 || bus.stall_o !== 6'b000000) begin
            n_fail++; $display("FAIL drain_release: we %b stall %b want 0/000000", bus.csr_we_o, bus.stall_o); end
        @(negedge clk); #1;
        n_checks++; if (flags !== 5'b11100 || bus.csr_wdata_o !== 32'h40) begin
            n_fail++; $display("FAIL drain_epc: flags %b data %h want 11100/00000040", flags, bus.csr_wdata_o); end
        @(negedge clk); #1;
        n_checks++; if (flags !== 5'b10111 || bus.new_pc_o !== 32'h200) begin
            n_fail++; $display("FAIL drain_cause: flags %b pc %h want 10111/00000200", flags, bus.new_pc_o); end
        clear_inputs();
    endtask

    task automatic test_mret();
        @(negedge clk);
        bus.mret_i = 1'b1; bus.mepc_i = 32'h84; bus.stallreq_ex_i = 1'b1;
        #1;
        n_checks++; if (flags !== 5'b10001 || bus.new_pc_o !== 32'h84) begin
            n_fail++; $display("FAIL mret_redirect: flags %b pc %h want 10001/00000084", flags, bus.new_pc_o); end
        n_checks++; if (bus.stall_o !== 6'b001111) begin n_fail++; $display("FAIL mret_stall: got %b want 001111", bus.stall_o); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++; if (flags !== 5'b00000 || bus.new_pc_o !== 32'h0) begin
            n_fail++; $display("FAIL mret_stays_idle: flags %b pc %h want 0", flags, bus.new_pc_o); end
    endtask

    task automatic test_int_mret_collision();
        @(negedge clk);
        bus.int_req_i = 1'b1; bus.int_en_i = 1'b1; bus.mret_i = 1'b1;
        bus.mepc_i = 32'h84; bus.epc_i = 32'h88; bus.mtvec_i = 32'h300;
        #1;
        n_checks++; if (flags !== 5'b00000 || bus.new_pc_o !== 32'h0) begin
            n_fail++; $display("FAIL collide_no_mret: flags %b pc %h want 0", flags, bus.new_pc_o); end
        @(negedge clk);
        bus.int_req_i = 1'b0; bus.mret_i = 1'b0;
        #1;
        n_checks++; if (flags !== 5'b11100 || bus.csr_wdata_o !== 32'h88) begin
            n_fail++; $display("FAIL collide_epc: flags %b data %h want 11100/00000088", flags, bus.csr_wdata_o); end
        @(negedge clk); #1;
        n_checks++; if (bus.new_pc_o !== 32'h300 || bus.int_ack_o !== 1'b1) begin
            n_fail++; $display("FAIL collide_cause: pc %h ack %b want 00000300/1", bus.new_pc_o, bus.int_ack_o); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_trap();
        @(negedge clk);
        bus.int_req_i = 1'b1; bus.int_en_i = 1'b1; bus.epc_i = 32'h50;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (flags !== 5'b00000 || bus.stall_o !== 6'b000000) begin
            n_fail++; $display("FAIL rst_in_epc: flags %b stall %b want 0", flags, bus.stall_o); end
        @(negedge clk);
        rst = 1'b0;
        bus.int_req_i = 1'b0;
        #1;
        n_checks++; if (flags !== 5'b00000) begin n_fail++; $display("FAIL rst_after_epc: flags %b want 00000", flags); end
        @(negedge clk); #1;
        n_checks++; if (bus.int_ack_o !== 1'b0 || bus.csr_we_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_no_cause: ack %b we %b want 0/0", bus.int_ack_o, bus.csr_we_o); end
        clear_inputs();
    endtask

    task automatic test_int_disabled();
        @(negedge clk);
        bus.int_req_i = 1'b1; bus.int_en_i = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (flags !== 5'b00000) begin n_fail++; $display("FAIL int_masked: flags %b want 00000", flags); end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.int_req_i = 1'b1; bus.int_en_i = 1'b1; bus.epc_i = 32'h60; bus.mtvec_i = 32'h400;
        @(negedge clk);
        @(negedge clk); #1;
        n_checks++; if (bus.int_ack_o !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ack: got %b want 1", bus.int_ack_o); end
        @(negedge clk); #1;
        n_checks++; if (flags !== 5'b00000) begin n_fail++; $display("FAIL b2b_idle_gap: flags %b want 00000", flags); end
        @(negedge clk);
        bus.int_req_i = 1'b0;
        #1;
        n_checks++; if (flags !== 5'b11100 || bus.csr_wdata_o !== 32'h60) begin
            n_fail++; $display("FAIL b2b_second_epc: flags %b data %h want 11100/00000060", flags, bus.csr_wdata_o); end
        @(negedge clk);
        @(negedge clk);
        clear_inputs();
    endtask

`ifdef CTRL_DRAIN_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge clk);
        bus.int_req_i = 1'b1; bus.int_en_i = 1'b1; bus.stallreq_mem_i = 1'b1; bus.epc_i = 32'h70;
        #1;
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_initial: got %b want 0", timeout); end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus.int_req_i = 1'b0;
            #1;
            n_checks++; if (bus.csr_we_o !== 1'b0 || bus.stall_o !== 6'b011111 || timeout !== 1'b0) begin
                n_fail++; $display("FAIL to_drain cyc%0d: we %b stall %b to %b want 0/011111/0", i, bus.csr_we_o, bus.stall_o, timeout); end
        end
        @(negedge clk); #1;
        n_checks++; if (flags !== 5'b11100 || timeout !== 1'b1) begin
            n_fail++; $display("FAIL to_forced_epc: flags %b to %b want 11100/1", flags, timeout); end
        for (int i = 0; i < 4; i++) @(negedge clk);
        #1;
        n_checks++; if (timeout !== 1'b1 || bus.stall_o !== 6'b011111 || flags !== 5'b00000) begin
            n_fail++; $display("FAIL to_sticky: to %b stall %b flags %b want 1/011111/00000", timeout, bus.stall_o, flags); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_reset_clear: got %b want 0", timeout); end
        clear_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_stall_priority();
        test_interrupt_entry();
        test_drain();
        test_mret();
        test_int_mret_collision();
        test_reset_mid_trap();
        test_int_disabled();
        test_back_to_back();
`ifdef CTRL_DRAIN_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
